pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port n_rst_i, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have ports stall_req_if_i, stall_req_id_i, stall_req_ex_i, stall_req_mem_i, input, 1 each, per-stage stall requests.
REQ-004 SHALL have ports trap_req_i, input, 1, and trap_pc_i, input, 32, trap entry request and target; requester holds both until trap_ack_o.
REQ-005 SHALL have ports mret_req_i, input, 1, and mret_pc_i, input, 32, trap-return request and target; same hold rule.
REQ-006 SHALL have port mem_busy_i, input, 1, outstanding data-memory transaction.
REQ-007 SHALL have port stall_o, output, 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-008 SHALL have ports flush_o, output, 1, and new_pc_o, output, 32, redirect to fetch unit.
REQ-009 SHALL have ports trap_ack_o, output, 1, and busy_o, output, 1 (FSM not IDLE).
REQ-010 SHALL have port drain_timeout_o, output, 1, sticky drain watchdog flag.

Function
REQ-011 SHALL implement FSM states IDLE, DRAIN, FLUSH, encoded 2 bits.
REQ-012 In IDLE, stall_o SHALL be combinational priority: mem -> 011111, else ex -> 001111, else id -> 000111, else if -> 000011, else 000000.
REQ-013 In IDLE with trap_req_i=1, SHALL latch trap_pc_i, pulse trap_ack_o for that cycle, go DRAIN if mem_busy_i=1 else FLUSH.
REQ-014 In IDLE with mret_req_i=1 and trap_req_i=0, SHALL latch mret_pc_i, pulse trap_ack_o, same transition rule; trap beats mret when simultaneous.
REQ-015 In DRAIN, stall_o SHALL be 011111; go FLUSH the cycle after mem_busy_i is sampled 0.
REQ-016 In FLUSH, SHALL assert flush_o=1, new_pc_o=latched target, stall_o=000000 for exactly one cycle, then go IDLE.
REQ-017 Outside FLUSH, flush_o SHALL be 0 and new_pc_o SHALL hold the last latched target.
REQ-018 trap_req_i/mret_req_i SHALL be ignored (no ack) while not IDLE; stage stall requests SHALL be ignored in DRAIN and FLUSH.
REQ-019 Minimum trap-to-flush latency SHALL be one cycle (ack cycle N, flush_o cycle N+1).
REQ-020 busy_o SHALL equal (state != IDLE).

Reset
REQ-021 On n_rst_i=0, asynchronously: state IDLE, flush_o 0, trap_ack_o 0, new_pc_o REBOOT_ADDRESS, drain_timeout_o 0, watchdog count 0.
REQ-022 Reset asserted mid-DRAIN or mid-FLUSH SHALL abandon the pending redirect; no flush after release.
REQ-023 While n_rst_i=0, stall_o SHALL be 000000.

Configuration
REQ-024 Macro PIPE_CTRL_DRAIN_TIMEOUT_EN defined: 8-bit counter clears on DRAIN entry, increments each DRAIN cycle; at count 255 with mem_busy_i still 1, SHALL force FLUSH next cycle and set drain_timeout_o (cleared only by reset).
REQ-025 Macro undefined: no counter; DRAIN waits indefinitely; drain_timeout_o tied 0.

Structure
REQ-026 Stall vector encodings, FSM state encodings, REBOOT_ADDRESS and INS_BUS_A width SHALL live in the shared defines package.
REQ-027 Watchdog SHALL be sub-module pipe_ctrl_wdt, instantiated only under PIPE_CTRL_DRAIN_TIMEOUT_EN; otherwise single flat module.

Verification
REQ-028 stall_req_ex_i=1, stall_req_if_i=1, IDLE -> stall_o=001111, flush_o=0.
REQ-029 trap_req_i=1, trap_pc_i=0x0000_0100, mem_busy_i=0 at cycle N -> trap_ack_o=1 at N; flush_o=1, new_pc_o=0x0000_0100 at N+1; IDLE at N+2.
REQ-030 trap_req_i=1, mem_busy_i=1 for 3 cycles -> DRAIN with stall_o=011111 for 3 cycles, flush_o one cycle after mem_busy_i drops.
REQ-031 trap_req_i=1 (pc 0x200) and mret_req_i=1 (pc 0x300) same cycle -> new_pc_o=0x200 on flush; mret held, acked in following IDLE cycle.
REQ-032 n_rst_i low during DRAIN -> IDLE, new_pc_o=REBOOT_ADDRESS, no flush_o after release.
REQ-033 With PIPE_CTRL_DRAIN_TIMEOUT_EN, mem_busy_i stuck 1 -> forced FLUSH after 255 DRAIN cycles, drain_timeout_o=1 until reset.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared defines for the pipeline controller: stall encodings,
//            FSM state encodings, bus width and reboot address.
// Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam int INS_BUS_A = 32;
  localparam logic [INS_BUS_A-1:0] REBOOT_ADDRESS = 32'h0000_1000;

  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_vec_t;

  // Bit order: [5]=WB [4]=MEM [3]=EX [2]=ID [1]=IF [0]=PC
  localparam stall_vec_t c_stall_none = 6'b000000;
  localparam stall_vec_t c_stall_if   = 6'b000011;
  localparam stall_vec_t c_stall_id   = 6'b000111;
  localparam stall_vec_t c_stall_ex   = 6'b001111;
  localparam stall_vec_t c_stall_mem  = 6'b011111;

  localparam logic [1:0] c_st_idle  = 2'b00;
  localparam logic [1:0] c_st_drain = 2'b01;
  localparam logic [1:0] c_st_flush = 2'b10;

  typedef struct packed {
    logic mem;
    logic ex;
    logic id;
    logic fetch;
  } stall_req_t;

  function automatic stall_vec_t stall_encode(input stall_req_t req);
    stall_vec_t v;
    if (req.mem)        v = c_stall_mem;
    else if (req.ex)    v = c_stall_ex;
    else if (req.id)    v = c_stall_id;
    else if (req.fetch) v = c_stall_if;
    else                v = c_stall_none;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Purpose  : Request/redirect bundle between the pipeline stages and
//            pipe_ctrl. master = pipeline side, slave = controller side.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
  ;

  logic                 stall_req_if_i;
  logic                 stall_req_id_i;
  logic                 stall_req_ex_i;
  logic                 stall_req_mem_i;
  logic                 trap_req_i;
  logic [INS_BUS_A-1:0] trap_pc_i;
  logic                 mret_req_i;
  logic [INS_BUS_A-1:0] mret_pc_i;
  logic                 mem_busy_i;

  stall_vec_t           stall_o;
  logic                 flush_o;
  logic [INS_BUS_A-1:0] new_pc_o;
  logic                 trap_ack_o;
  logic                 busy_o;
  logic                 drain_timeout_o;

  modport master (
    output stall_req_if_i, stall_req_id_i, stall_req_ex_i, stall_req_mem_i,
    output trap_req_i, trap_pc_i, mret_req_i, mret_pc_i, mem_busy_i,
    input  stall_o, flush_o, new_pc_o, trap_ack_o, busy_o, drain_timeout_o
  );

  modport slave (
    input  stall_req_if_i, stall_req_id_i, stall_req_ex_i, stall_req_mem_i,
    input  trap_req_i, trap_pc_i, mret_req_i, mret_pc_i, mem_busy_i,
    output stall_o, flush_o, new_pc_o, trap_ack_o, busy_o, drain_timeout_o
  );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_wdt.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_wdt
// Purpose  : Drain watchdog; forces the drain to end after the count reaches
//            its limit with memory still busy. Built only when
//            PIPE_CTRL_DRAIN_TIMEOUT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`ifdef PIPE_CTRL_DRAIN_TIMEOUT_EN
module pipe_ctrl_wdt (
  input  wire logic clk_i,
  input  wire logic n_rst_i,
  input  wire logic i_clear,
  input  wire logic i_active,
  input  wire logic i_mem_busy,
  output logic      o_expire,
  output logic      o_timeout
);

  localparam logic [7:0] c_cnt_limit = 8'hFF;

  logic [7:0] r_cnt;
  logic       r_timeout;

  assign o_expire  = i_active & i_mem_busy & (r_cnt == c_cnt_limit);
  assign o_timeout = r_timeout;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_cnt <= 8'd0;
    end else if (i_clear) begin
      r_cnt <= 8'd0;
    end else if (i_active) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Sticky until reset so software can see a drain was abandoned
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_timeout <= 1'b0;
    end else if (o_expire) begin
      r_timeout <= 1'b1;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline stall/flush controller with trap entry and return
//            redirect. Optional drain watchdog: PIPE_CTRL_DRAIN_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  wire logic   clk_i,
  input  wire logic   n_rst_i,
  pipe_ctrl_if.slave  bus
);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [INS_BUS_A-1:0] r_target;
  logic                 w_req;
  logic                 w_ack;
  logic                 w_expire;
  logic                 w_timeout;
  stall_vec_t           w_stall;
  stall_req_t           w_stage_req;

  assign w_req = bus.trap_req_i | bus.mret_req_i;
  assign w_ack = n_rst_i & (r_state == c_st_idle) & w_req;

  assign w_stage_req = '{mem:   bus.stall_req_mem_i,
                         ex:    bus.stall_req_ex_i,
                         id:    bus.stall_req_id_i,
                         fetch: bus.stall_req_if_i};

`ifdef PIPE_CTRL_DRAIN_TIMEOUT_EN
  logic w_drain_entry;
  assign w_drain_entry = w_ack & bus.mem_busy_i;

  pipe_ctrl_wdt u_wdt (
    .clk_i      (clk_i),
    .n_rst_i    (n_rst_i),
    .i_clear    (w_drain_entry),
    .i_active   (r_state == c_st_drain),
    .i_mem_busy (bus.mem_busy_i),
    .o_expire   (w_expire),
    .o_timeout  (w_timeout)
  );
`else
  assign w_expire  = 1'b0;
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_req) begin
          w_state_nxt = bus.mem_busy_i ? c_st_drain : c_st_flush;
        end
      end
      c_st_drain: begin
        if (!bus.mem_busy_i || w_expire) begin
          w_state_nxt = c_st_flush;
        end
      end
      c_st_flush: w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Trap wins over mret when both are presented together
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_target <= REBOOT_ADDRESS;
    end else if (w_ack) begin
      r_target <= bus.trap_req_i ? bus.trap_pc_i : bus.mret_pc_i;
    end
  end

  always_comb begin
    w_stall = c_stall_none;
    if (n_rst_i) begin
      case (r_state)
        c_st_idle:  w_stall = stall_encode(w_stage_req);
        c_st_drain: w_stall = c_stall_mem;
        default:    w_stall = c_stall_none;
      endcase
    end
  end

  assign bus.stall_o         = w_stall;
  assign bus.flush_o         = (r_state == c_st_flush);
  assign bus.new_pc_o        = r_target;
  assign bus.trap_ack_o      = w_ack;
  assign bus.busy_o          = (r_state != c_st_idle);
  assign bus.drain_timeout_o = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Directed self-checking bench for pipe_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk_i;
  logic n_rst_i;
  int   n_checks;
  int   n_pass;

  pipe_ctrl_if u_if ();

  pipe_ctrl u_dut (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .bus     (u_if.slave)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_stage(input logic [3:0] req);
    u_if.stall_req_mem_i = req[3];
    u_if.stall_req_ex_i  = req[2];
    u_if.stall_req_id_i  = req[1];
    u_if.stall_req_if_i  = req[0];
  endtask

  logic [3:0] v_req [8];
  logic [5:0] v_exp [8];
  int         drain_cnt;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_rst_i  = 1'b0;
    set_stage(4'b1000);
    u_if.trap_req_i = 1'b1;
    u_if.trap_pc_i  = 32'h0000_0AAA;
    u_if.mret_req_i = 1'b0;
    u_if.mret_pc_i  = 32'h0;
    u_if.mem_busy_i = 1'b0;

    v_req[0] = 4'b0000; v_exp[0] = 6'b000000;
    v_req[1] = 4'b0001; v_exp[1] = 6'b000011;
    v_req[2] = 4'b0010; v_exp[2] = 6'b000111;
    v_req[3] = 4'b0011; v_exp[3] = 6'b000111;
    v_req[4] = 4'b0100; v_exp[4] = 6'b001111;
    v_req[5] = 4'b0101; v_exp[5] = 6'b001111;
    v_req[6] = 4'b1000; v_exp[6] = 6'b011111;
    v_req[7] = 4'b1111; v_exp[7] = 6'b011111;

    // Reset state: requests present must not leak through
    repeat (2) @(negedge clk_i);
    check("rst_stall",    32'(u_if.stall_o),      32'h0);
    check("rst_new_pc",   u_if.new_pc_o,          32'h0000_1000);
    check("rst_flush",    32'(u_if.flush_o),      32'h0);
    check("rst_ack",      32'(u_if.trap_ack_o),   32'h0);
    check("rst_busy",     32'(u_if.busy_o),       32'h0);
    check("rst_timeout",  32'(u_if.drain_timeout_o), 32'h0);

    u_if.trap_req_i = 1'b0;
    set_stage(4'b0000);
    next_cycle();
    n_rst_i = 1'b1;

    // Stall priority in IDLE
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      set_stage(v_req[i]);
      @(negedge clk_i);
      check($sformatf("idle_stall_%0d", i), 32'(u_if.stall_o), 32'(v_exp[i]));
      check($sformatf("idle_flush_%0d", i), 32'(u_if.flush_o), 32'h0);
    end

    // Trap, memory idle: ack N, flush N+1, idle N+2
    next_cycle();
    set_stage(4'b0000);
    u_if.trap_req_i = 1'b1;
    u_if.trap_pc_i  = 32'h0000_0100;
    @(negedge clk_i);
    check("t1_ack",   32'(u_if.trap_ack_o), 32'h1);
    check("t1_flushN", 32'(u_if.flush_o),   32'h0);
    next_cycle();
    u_if.trap_req_i = 1'b0;
    set_stage(4'b1000);
    @(negedge clk_i);
    check("t1_flush",  32'(u_if.flush_o),   32'h1);
    check("t1_new_pc", u_if.new_pc_o,       32'h0000_0100);
    check("t1_stall",  32'(u_if.stall_o),   32'h0);
    check("t1_busy",   32'(u_if.busy_o),    32'h1);
    next_cycle();
    set_stage(4'b0000);
    @(negedge clk_i);
    check("t1_idle_busy",  32'(u_if.busy_o),  32'h0);
    check("t1_idle_flush", 32'(u_if.flush_o), 32'h0);
    check("t1_hold_pc",    u_if.new_pc_o,     32'h0000_0100);

    // Trap with memory busy 3 cycles; mret and stage requests ignored meanwhile
    next_cycle();
    u_if.trap_req_i = 1'b1;
    u_if.trap_pc_i  = 32'h0000_0180;
    u_if.mem_busy_i = 1'b1;
    @(negedge clk_i);
    check("t2_ack", 32'(u_if.trap_ack_o), 32'h1);
    next_cycle();
    u_if.trap_req_i = 1'b0;
    u_if.mret_req_i = 1'b1;
    u_if.mret_pc_i  = 32'h0000_0999;
    set_stage(4'b0001);
    @(negedge clk_i);
    check("t2_drain1_stall", 32'(u_if.stall_o),    32'h1F);
    check("t2_drain1_ack",   32'(u_if.trap_ack_o), 32'h0);
    check("t2_drain1_busy",  32'(u_if.busy_o),     32'h1);
    next_cycle();
    @(negedge clk_i);
    check("t2_drain2_stall", 32'(u_if.stall_o),    32'h1F);
    next_cycle();
    u_if.mem_busy_i = 1'b0;
    @(negedge clk_i);
    check("t2_drain3_stall", 32'(u_if.stall_o),    32'h1F);
    check("t2_drain3_flush", 32'(u_if.flush_o),    32'h0);
    next_cycle();
    @(negedge clk_i);
    check("t2_flush",    32'(u_if.flush_o),    32'h1);
    check("t2_new_pc",   u_if.new_pc_o,        32'h0000_0180);
    check("t2_flush_ack", 32'(u_if.trap_ack_o), 32'h0);
    next_cycle();
    @(negedge clk_i);
    check("t2_mret_ack",   32'(u_if.trap_ack_o), 32'h1);
    check("t2_idle_stall", 32'(u_if.stall_o),    32'h03);
    next_cycle();
    u_if.mret_req_i = 1'b0;
    set_stage(4'b0000);
    @(negedge clk_i);
    check("t2_mret_flush", 32'(u_if.flush_o), 32'h1);
    check("t2_mret_pc",    u_if.new_pc_o,     32'h0000_0999);

    // Simultaneous trap and mret: trap first, mret next IDLE cycle
    next_cycle();
    u_if.trap_req_i = 1'b1;
    u_if.trap_pc_i  = 32'h0000_0200;
    u_if.mret_req_i = 1'b1;
    u_if.mret_pc_i  = 32'h0000_0300;
    @(negedge clk_i);
    check("t3_ack", 32'(u_if.trap_ack_o), 32'h1);
    next_cycle();
    u_if.trap_req_i = 1'b0;
    @(negedge clk_i);
    check("t3_flush",  32'(u_if.flush_o),    32'h1);
    check("t3_new_pc", u_if.new_pc_o,        32'h0000_0200);
    check("t3_no_ack", 32'(u_if.trap_ack_o), 32'h0);
    next_cycle();
    @(negedge clk_i);
    check("t3_mret_ack", 32'(u_if.trap_ack_o), 32'h1);
    next_cycle();
    u_if.mret_req_i = 1'b0;
    @(negedge clk_i);
    check("t3_mret_flush", 32'(u_if.flush_o), 32'h1);
    check("t3_mret_pc",    u_if.new_pc_o,     32'h0000_0300);

    // Reset mid-DRAIN abandons the redirect
    next_cycle();
    u_if.trap_req_i = 1'b1;
    u_if.trap_pc_i  = 32'h0000_0400;
    u_if.mem_busy_i = 1'b1;
    next_cycle();
    u_if.trap_req_i = 1'b0;
    @(negedge clk_i);
    check("t4_drain_busy", 32'(u_if.busy_o), 32'h1);
    #2;
    n_rst_i = 1'b0;
    #1;
    check("t4_rst_busy",  32'(u_if.busy_o),  32'h0);
    check("t4_rst_pc",    u_if.new_pc_o,     32'h0000_1000);
    check("t4_rst_stall", 32'(u_if.stall_o), 32'h0);
    next_cycle();
    u_if.mem_busy_i = 1'b0;
    n_rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check($sformatf("t4_no_flush_%0d", i), 32'(u_if.flush_o), 32'h0);
      next_cycle();
    end

`ifdef PIPE_CTRL_DRAIN_TIMEOUT_EN
    // Memory stuck busy: watchdog forces the flush
    u_if.trap_req_i = 1'b1;
    u_if.trap_pc_i  = 32'h0000_0500;
    u_if.mem_busy_i = 1'b1;
    next_cycle();
    u_if.trap_req_i = 1'b0;
    drain_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (u_if.flush_o) break;
      if (u_if.busy_o) drain_cnt++;
      next_cycle();
    end
    check("t5_flush",     32'(u_if.flush_o), 32'h1);
    check("t5_drain_len", 32'((drain_cnt >= 255) && (drain_cnt <= 256)), 32'h1);
    check("t5_pc",        u_if.new_pc_o,     32'h0000_0500);
    repeat (3) next_cycle();
    @(negedge clk_i);
    check("t5_sticky", 32'(u_if.drain_timeout_o), 32'h1);
    n_rst_i = 1'b0;
    #1;
    check("t5_rst_clear", 32'(u_if.drain_timeout_o), 32'h0);
    n_rst_i = 1'b1;
    u_if.mem_busy_i = 1'b0;
`else
    drain_cnt = 0;
    @(negedge clk_i);
    check("t5_timeout_tied", 32'(u_if.drain_timeout_o), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
